// File: rtl/fpadd_sched_pkg.sv
// fpadd_sched_pkg: shared types and constants for the FP-adder scheduler.
//   W        operand/result width (IEEE-754 single precision)
//   state_e  scheduler FSM states
//   owner_t  tag naming which requester owns the in-flight operation
package fpadd_sched_pkg;

    localparam int W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef logic owner_t;

endpackage

// File: rtl/fpadd_sched_if.sv
// fpadd_sched_if: bundles the client request/response channels, the shared
// datapath operands/result and the status/debug signals of fpadd_sched.
//   slave  modport: the scheduler side
//   master modport: the client/datapath side (testbench or parent logic)
//
// Handshake rule for every channel: a transfer happens in a cycle where
// valid && ready are both high at the rising clock edge. The payload is
// sampled only in that cycle. Before ready the source may change or drop
// its payload freely. Once the scheduler raises resp*_valid, it holds valid
// and resp_sum until the matching resp*_ready is seen.
interface fpadd_sched_if;
    import fpadd_sched_pkg::*;

    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         resp0_valid;
    logic         resp0_ready;
    logic         resp1_valid;
    logic         resp1_ready;
    logic [W-1:0] resp_sum;
    logic [W-1:0] dp_a;
    logic [W-1:0] dp_b;
    logic [W-1:0] dp_res;
    logic         busy;
    logic [1:0]   state;     // debug view of the scheduler FSM

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  resp0_ready, resp1_ready, dp_res,
        output req0_ready, req1_ready,
        output resp0_valid, resp1_valid, resp_sum,
        output dp_a, dp_b, busy, state
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output resp0_ready, resp1_ready, dp_res,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp1_valid, resp_sum,
        input  dp_a, dp_b, busy, state
    );

endinterface

// File: rtl/fpadd_rr_arb2.sv
// fpadd_rr_arb2: combinational two-way round-robin grant.
//   req0, req1  request lines
//   rr_last     requester that won the previous grant
//   gnt0, gnt1  one-hot (or zero) grant
// With both requesting, the requester that did not win last time is granted.
module fpadd_rr_arb2
    import fpadd_sched_pkg::*;
(
    input  logic   req0,
    input  logic   req1,
    input  owner_t rr_last,
    output logic   gnt0,
    output logic   gnt1
);

    assign gnt0 = req0 && (!req1 || (rr_last == 1'b1));
    assign gnt1 = req1 && (!req0 || (rr_last == 1'b0));

endmodule

// File: rtl/fpadd_sched.sv
// fpadd_sched: shares one combinational FP adder between two requesters.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         fpadd_sched_if.slave: request channels, response channels,
//               datapath operands/result, busy and debug state
// Parameter DP_LAT (1..15) is the number of cycles the datapath is given to
// settle; the operands are held constant for that whole window so the adder
// can be constrained as a multicycle path.
module fpadd_sched
    import fpadd_sched_pkg::*;
#(
    parameter int DP_LAT = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    fpadd_sched_if.slave  bus
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_EXEC = EXEC;
    localparam logic [1:0] S_RESP = RESP;

    // The counter is loaded with DP_LAT-1 so the capture lands on the last
    // EXEC cycle; DP_LAT=1 loads 0 and captures on the first EXEC cycle.
    localparam logic [3:0] CNT_INIT = 4'(DP_LAT - 1);

    logic [1:0]   state;
    owner_t       rr_last;
    owner_t       owner;
    logic [3:0]   cnt;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] res_q;

    logic gnt0;
    logic gnt1;
    logic ready0;
    logic ready1;
    logic accept;
    logic resp_take;

    fpadd_rr_arb2 u_arb (
        .req0    (bus.req0_valid),
        .req1    (bus.req1_valid),
        .rr_last (rr_last),
        .gnt0    (gnt0),
        .gnt1    (gnt1)
    );

    assign ready0    = (state == S_IDLE) && gnt0;
    assign ready1    = (state == S_IDLE) && gnt1;
    assign accept    = ready0 || ready1;
    assign resp_take = (owner == 1'b1) ? bus.resp1_ready : bus.resp0_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            rr_last <= 1'b1;
            owner   <= 1'b0;
            cnt     <= 4'd0;
            op_a    <= '0;
            op_b    <= '0;
            res_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        // ready1 alone identifies the winner: grants are exclusive
                        op_a    <= ready1 ? bus.req1_a : bus.req0_a;
                        op_b    <= ready1 ? bus.req1_b : bus.req0_b;
                        owner   <= ready1;
                        rr_last <= ready1;
                        cnt     <= CNT_INIT;
                        state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (cnt == 4'd0) begin
                        res_q <= bus.dp_res;
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (resp_take) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req0_ready  = ready0;
    assign bus.req1_ready  = ready1;
    assign bus.resp0_valid = (state == S_RESP) && (owner == 1'b0);
    assign bus.resp1_valid = (state == S_RESP) && (owner == 1'b1);
    assign bus.resp_sum    = (state == S_RESP) ? res_q : '0;
    // Operand registers feed the adder directly; they only move on accept.
    assign bus.dp_a        = op_a;
    assign bus.dp_b        = op_b;
    assign bus.busy        = (state != S_IDLE);
    assign bus.state       = state;

endmodule

// File: tb/tb_fpadd_sched.sv
// tb_fpadd_sched: self-checking bench for fpadd_sched. Two instances are
// built, one with DP_LAT=3 and one with DP_LAT=1, each with its own adder
// stand-in driving dp_res from dp_a/dp_b.
module tb_fpadd_sched;
    import fpadd_sched_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors    = 0;
    int miscompares = 0;

    // expected responses: sum, owner and the cycle it must appear in
    logic [W-1:0] exp_q[$];
    logic         own_q[$];
    int           due_q[$];

    // Adder stand-in: exact for the directed vectors, otherwise an arbitrary
    // but operand-dependent mix (the scheduler never looks inside the value).
    function automatic logic [31:0] dp_model(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        if (a == 32'hC0A0_0000 && b == 32'h40A0_0000) return 32'h0000_0000;
        return (a + b) ^ {b[15:0], a[31:16]};
    endfunction

    fpadd_sched_if bus3 ();
    fpadd_sched_if bus1 ();

    fpadd_sched #(.DP_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));
    fpadd_sched #(.DP_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    assign bus3.dp_res = dp_model(bus3.dp_a, bus3.dp_b);
    assign bus1.dp_res = dp_model(bus1.dp_a, bus1.dp_b);

    logic [102:0] outs3;
    logic [102:0] outs1;
    assign outs3 = {bus3.req0_ready, bus3.req1_ready, bus3.resp0_valid, bus3.resp1_valid,
                    bus3.busy, bus3.resp_sum, bus3.dp_a, bus3.dp_b, bus3.state};
    assign outs1 = {bus1.req0_ready, bus1.req1_ready, bus1.resp0_valid, bus1.resp1_valid,
                    bus1.busy, bus1.resp_sum, bus1.dp_a, bus1.dp_b, bus1.state};

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus3.req0_valid = 1'b0; bus3.req0_a = '0; bus3.req0_b = '0;
        bus3.req1_valid = 1'b0; bus3.req1_a = '0; bus3.req1_b = '0;
        bus3.resp0_ready = 1'b0; bus3.resp1_ready = 1'b0;
        bus1.req0_valid = 1'b0; bus1.req0_a = '0; bus1.req0_b = '0;
        bus1.req1_valid = 1'b0; bus1.req1_a = '0; bus1.req1_b = '0;
        bus1.resp0_ready = 1'b0; bus1.resp1_ready = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (outs3 !== '0) begin
            miscompares++;
            $display("FAIL reset_outs3: got %h expected 0", outs3);
        end
        vectors++;
        if (outs1 !== '0) begin
            miscompares++;
            $display("FAIL reset_outs1: got %h expected 0", outs1);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int t;
        bus3.resp0_ready = 1'b1;
        bus3.resp1_ready = 1'b1;
        @(negedge clk);
        bus3.req0_valid = 1'b1;
        bus3.req0_a = 32'h3F80_0000;
        bus3.req0_b = 32'h4000_0000;
        #1;
        t = cyc;
        vectors++;
        if ({bus3.req0_ready, bus3.req1_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL single_accept: got %b expected 10", {bus3.req0_ready, bus3.req1_ready});
        end
        @(negedge clk);
        bus3.req0_valid = 1'b0;
        bus3.req0_a = $urandom;
        for (int k = 1; k <= 3; k++) begin
            #1;
            vectors++;
            if ({bus3.resp0_valid, bus3.resp1_valid, bus3.busy, bus3.dp_a, bus3.dp_b} !==
                {3'b001, 32'h3F80_0000, 32'h4000_0000}) begin
                miscompares++;
                $display("FAIL single_exec%0d: got rv=%b%b busy=%b dp=%h/%h expected rv=00 busy=1 dp=3f800000/40000000",
                         k, bus3.resp0_valid, bus3.resp1_valid, bus3.busy, bus3.dp_a, bus3.dp_b);
            end
            @(negedge clk);
        end
        #1;
        vectors++;
        if ({bus3.resp0_valid, bus3.resp1_valid, bus3.resp_sum} !== {2'b10, 32'h4040_0000} || (cyc - t) != 4) begin
            miscompares++;
            $display("FAIL single_resp: got rv=%b%b sum=%h at +%0d expected rv=10 sum=40400000 at +4",
                     bus3.resp0_valid, bus3.resp1_valid, bus3.resp_sum, cyc - t);
        end
        @(negedge clk);
        #1;
        vectors++;
        if ({bus3.busy, bus3.resp0_valid, bus3.resp_sum} !== '0) begin
            miscompares++;
            $display("FAIL single_idle: got busy=%b rv0=%b sum=%h expected 0/0/0",
                     bus3.busy, bus3.resp0_valid, bus3.resp_sum);
        end
    endtask

    task automatic test_round_robin();
        logic exp_owner = 1'b0;   // requester 0 wins first after reset
        int   accepts = 0;
        int   budget  = 0;
        logic responded;
        logic [W-1:0] got_sum;
        apply_reset();
        bus3.resp0_ready = 1'b1;
        bus3.resp1_ready = 1'b1;
        exp_q.delete(); own_q.delete(); due_q.delete();
        while ((accepts < 8 || exp_q.size() > 0) && budget < 300) begin
            @(negedge clk);
            bus3.req0_valid = (accepts < 8);
            bus3.req1_valid = (accepts < 8);
            bus3.req0_a = $urandom; bus3.req0_b = $urandom;
            bus3.req1_a = $urandom; bus3.req1_b = $urandom;
            #1;
            responded = bus3.resp0_valid || bus3.resp1_valid;
            if (responded) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rr_spurious_resp: got rv=%b%b expected none", bus3.resp0_valid, bus3.resp1_valid);
                end else begin
                    got_sum = bus3.resp_sum;
                    if ({bus3.resp0_valid, bus3.resp1_valid} !== (own_q[0] ? 2'b01 : 2'b10) ||
                        got_sum !== exp_q[0] || cyc != due_q[0]) begin
                        miscompares++;
                        $display("FAIL rr_resp: got rv=%b%b sum=%h cyc=%0d expected owner=%0d sum=%h cyc=%0d",
                                 bus3.resp0_valid, bus3.resp1_valid, got_sum, cyc, own_q[0], exp_q[0], due_q[0]);
                    end
                    void'(exp_q.pop_front()); void'(own_q.pop_front()); void'(due_q.pop_front());
                end
            end
            if (bus3.req0_ready || bus3.req1_ready) begin
                vectors++;
                if ({bus3.req0_ready, bus3.req1_ready} !== (exp_owner ? 2'b01 : 2'b10) ||
                    exp_q.size() != 0 || responded) begin
                    miscompares++;
                    $display("FAIL rr_grant: got %b%b pending=%0d resp_now=%b expected grant=%0d pending=0 resp_now=0",
                             bus3.req0_ready, bus3.req1_ready, exp_q.size(), responded, exp_owner);
                end
                exp_q.push_back(exp_owner ? dp_model(bus3.req1_a, bus3.req1_b)
                                          : dp_model(bus3.req0_a, bus3.req0_b));
                own_q.push_back(exp_owner);
                due_q.push_back(cyc + 4);
                exp_owner = !exp_owner;
                accepts++;
            end else if (exp_q.size() == 0 && !responded && accepts < 8) begin
                vectors++;
                miscompares++;
                $display("FAIL rr_stall: got no grant at cyc %0d expected grant=%0d", cyc, exp_owner);
            end
            budget++;
        end
        vectors++;
        if (budget >= 300) begin
            miscompares++;
            $display("FAIL rr_timeout: got %0d accepts %0d pending expected 8 accepts 0 pending", accepts, exp_q.size());
        end
        bus3.req0_valid = 1'b0;
        bus3.req1_valid = 1'b0;
    endtask

    task automatic test_resp_stall();
        logic [W-1:0] exp_sum;
        @(negedge clk);
        bus3.resp0_ready = 1'b0;
        bus3.req0_valid = 1'b1;
        bus3.req0_a = $urandom; bus3.req0_b = $urandom;
        exp_sum = dp_model(bus3.req0_a, bus3.req0_b);
        #1;
        vectors++;
        if ({bus3.req0_ready, bus3.req1_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL stall_accept: got %b%b expected 10", bus3.req0_ready, bus3.req1_ready);
        end
        @(negedge clk);
        bus3.req1_valid = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            bus3.req0_a = $urandom; bus3.req1_a = $urandom;
            #1;
            vectors++;
            if ({bus3.req0_ready, bus3.req1_ready, bus3.resp0_valid, bus3.resp1_valid, bus3.resp_sum} !==
                {4'b0010, exp_sum}) begin
                miscompares++;
                $display("FAIL stall_hold%0d: got rdy=%b%b rv=%b%b sum=%h expected rdy=00 rv=10 sum=%h", k,
                         bus3.req0_ready, bus3.req1_ready, bus3.resp0_valid, bus3.resp1_valid, bus3.resp_sum, exp_sum);
            end
            @(negedge clk);
        end
        bus3.resp0_ready = 1'b1;
        bus3.resp1_ready = 1'b1;
        #1;
        vectors++;
        if ({bus3.req0_ready, bus3.req1_ready, bus3.resp0_valid} !== 3'b001) begin
            miscompares++;
            $display("FAIL stall_release: got rdy=%b%b rv0=%b expected rdy=00 rv0=1",
                     bus3.req0_ready, bus3.req1_ready, bus3.resp0_valid);
        end
        @(negedge clk);
        #1;
        // requester 0 won last, so requester 1 takes this one
        vectors++;
        if ({bus3.req0_ready, bus3.req1_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL stall_next_grant: got %b%b expected 01", bus3.req0_ready, bus3.req1_ready);
        end
        @(negedge clk);
        bus3.req0_valid = 1'b0;
        bus3.req1_valid = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_dp_lat1();
        logic         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_sum;
        bus1.resp0_ready = 1'b1;
        bus1.resp1_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            id = (n == 0) ? 1'b1 : 1'(n % 2);
            a  = (n == 0) ? 32'hC0A0_0000 : $urandom;
            b  = (n == 0) ? 32'h40A0_0000 : $urandom;
            exp_sum = dp_model(a, b);
            @(negedge clk);
            bus1.req0_valid = !id; bus1.req1_valid = id;
            bus1.req0_a = a; bus1.req0_b = b; bus1.req1_a = a; bus1.req1_b = b;
            #1;
            vectors++;
            if ({bus1.req0_ready, bus1.req1_ready} !== (id ? 2'b01 : 2'b10)) begin
                miscompares++;
                $display("FAIL lat1_accept%0d: got %b%b expected grant=%0d", n, bus1.req0_ready, bus1.req1_ready, id);
            end
            @(negedge clk);
            bus1.req0_valid = 1'b0; bus1.req1_valid = 1'b0;
            #1;
            vectors++;
            if ({bus1.resp0_valid, bus1.resp1_valid, bus1.busy} !== 3'b001) begin
                miscompares++;
                $display("FAIL lat1_exec%0d: got rv=%b%b busy=%b expected rv=00 busy=1",
                         n, bus1.resp0_valid, bus1.resp1_valid, bus1.busy);
            end
            @(negedge clk);
            #1;
            vectors++;
            if ({bus1.resp0_valid, bus1.resp1_valid, bus1.resp_sum} !== {(id ? 2'b01 : 2'b10), exp_sum}) begin
                miscompares++;
                $display("FAIL lat1_resp%0d: got rv=%b%b sum=%h expected owner=%0d sum=%h",
                         n, bus1.resp0_valid, bus1.resp1_valid, bus1.resp_sum, id, exp_sum);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus3.resp0_ready = 1'b1;
        bus3.resp1_ready = 1'b1;
        bus3.req0_valid = 1'b1;
        bus3.req0_a = $urandom | 32'h1; bus3.req0_b = $urandom;
        @(negedge clk);
        bus3.req0_valid = 1'b0;
        #1;
        vectors++;
        if (bus3.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_busy: got %b expected 1", bus3.busy);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (outs3 !== '0 || outs1 !== '0) begin
            miscompares++;
            $display("FAIL rstmid_async: got %h / %h expected 0 / 0", outs3, outs1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            vectors++;
            if ({bus3.resp0_valid, bus3.resp1_valid, bus3.busy} !== 3'b000) begin
                miscompares++;
                $display("FAIL rstmid_no_resp%0d: got rv=%b%b busy=%b expected 000",
                         k, bus3.resp0_valid, bus3.resp1_valid, bus3.busy);
            end
        end
        @(negedge clk);
        bus3.req0_valid = 1'b1; bus3.req1_valid = 1'b1;
        bus3.req0_a = $urandom; bus3.req1_a = $urandom;
        #1;
        vectors++;
        if ({bus3.req0_ready, bus3.req1_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL rstmid_grant: got %b%b expected 10", bus3.req0_ready, bus3.req1_ready);
        end
        @(negedge clk);
        bus3.req0_valid = 1'b0; bus3.req1_valid = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_operand_stable();
        logic [W-1:0] a1;
        logic [W-1:0] b1;
        logic [W-1:0] exp_sum;
        a1 = $urandom; b1 = $urandom;
        exp_sum = dp_model(a1, b1);
        bus3.resp1_ready = 1'b0;
        @(negedge clk);
        bus3.req1_valid = 1'b1;
        bus3.req1_a = a1; bus3.req1_b = b1;
        #1;
        vectors++;
        if ({bus3.req0_ready, bus3.req1_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL stable_accept: got %b%b expected 01", bus3.req0_ready, bus3.req1_ready);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus3.req1_a = $urandom; bus3.req1_b = $urandom;
            bus3.req1_valid = 1'($urandom_range(0, 1));
            #1;
            vectors++;
            if ({bus3.req1_ready, bus3.dp_a, bus3.dp_b} !== {1'b0, a1, b1}) begin
                miscompares++;
                $display("FAIL stable_exec%0d: got rdy1=%b dp=%h/%h expected rdy1=0 dp=%h/%h",
                         k, bus3.req1_ready, bus3.dp_a, bus3.dp_b, a1, b1);
            end
        end
        @(negedge clk);
        bus3.req1_valid = 1'b0;
        bus3.resp1_ready = 1'b1;
        #1;
        vectors++;
        if ({bus3.resp1_valid, bus3.resp_sum, bus3.dp_a} !== {1'b1, exp_sum, a1}) begin
            miscompares++;
            $display("FAIL stable_resp: got rv1=%b sum=%h dp_a=%h expected rv1=1 sum=%h dp_a=%h",
                     bus3.resp1_valid, bus3.resp_sum, bus3.dp_a, exp_sum, a1);
        end
        @(negedge clk);
        #1;
        vectors++;
        if ({bus3.busy, bus3.dp_a, bus3.dp_b} !== {1'b0, a1, b1}) begin
            miscompares++;
            $display("FAIL stable_idle: got busy=%b dp=%h/%h expected busy=0 dp=%h/%h",
                     bus3.busy, bus3.dp_a, bus3.dp_b, a1, b1);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_resp_stall();
        test_dp_lat1();
        test_reset_mid();
        test_operand_stable();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fpadd_sched.md
Name: fpadd_sched

Overview:
Two-requester scheduler that shares one combinational single-precision FP adder datapath (compare/align/add/normalize chain, 32-bit a, b -> res) between two clients. It arbitrates round-robin and holds the datapath operands stable for a multicycle-path window of DP_LAT cycles. It then captures the sum and returns it to the owning requester over a valid/ready handshake. It sits between client logic and the adder, and the adder itself stays purely combinational.

Parameters:
W, 32, operand/result width (IEEE-754 single).
DP_LAT, 3, cycles the datapath is given to settle (multicycle constraint); legal range 1..15.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operand pair
req0_ready  out  1  requester 0 accepted this cycle
req0_a  in  W  operand a
req0_b  in  W  operand b
req1_valid  in  1  requester 1 has an operand pair
req1_ready  out  1  requester 1 accepted this cycle
req1_a  in  W  operand a
req1_b  in  W  operand b
resp0_valid  out  1  result for requester 0
resp0_ready  in  1  requester 0 takes result
resp1_valid  out  1  result for requester 1
resp1_ready  in  1  requester 1 takes result
resp_sum  out  W  result, shared by both response channels
dp_a  out  W  datapath operand a
dp_b  out  W  datapath operand b
dp_res  in  W  datapath sum
busy  out  1  state != IDLE

Behaviour:
- Reset state: one clock (clk), asynchronous active-low reset (rst_n). Assertion takes effect immediately. On reset: state=IDLE, rr_last=1 so requester 0 wins first, cnt=0, owner=0, op_a/op_b/res_q=0, and every output is 0.
- FSM IDLE: grant = requester with valid set. If both are valid, grant goes to the one != rr_last. reqN_ready = (state==IDLE) && grant==N, combinational from valid and rr_last. At most one ready per cycle.
- On handshake (valid&&ready): latch a/b into op_a/op_b, owner=N, rr_last=N, cnt=DP_LAT-1, go to EXEC.
- FSM EXEC: dp_a/dp_b = op_a/op_b, registered. They change only on accept and are stable for the whole EXEC window. cnt decrements each cycle. In the cycle with cnt==0, res_q<=dp_res and the FSM goes to RESP.
- FSM RESP: resp<owner>_valid=1 and resp_sum=res_q. The other resp_valid is 0. On resp<owner>_ready go to IDLE. While waiting, valid and sum are held and both req ready are 0.
- Latency: accept in cycle t gives resp_valid high in cycle t+DP_LAT+1. Minimum initiation interval is DP_LAT+2 cycles, because there is no accept in the same cycle as the response leaves.
- Input rules: requests are sampled only at the handshake. Operand changes or valid drop before ready are ignored. Once accepted, a request is never lost except by reset.
- Reset mid-operation: the operation is aborted and no response is issued. After release, arbitration restarts from rr_last=1.
- The block never inspects FP fields. Zero, denormal, inf and NaN pass through unchanged, and correctness of dp_res is the datapath's responsibility.
- cnt width is 4 bits. DP_LAT=1 gives a single EXEC cycle with no underflow.
- resp_sum is 0 outside RESP: it is driven from res_q gated by state==RESP.

Decomposition:
- Package fpadd_sched_pkg holds: the state enum {IDLE, EXEC, RESP}, W=32, and the owner/tag type (1 bit).
- One sub-module, fpadd_rr_arb2: a combinational 2-way round-robin grant from {req0_valid, req1_valid, rr_last}. rr_last stays in the parent.

Test Plan:
1. DP_LAT=3, req0 a=0x3F800000 b=0x40000000, model dp_res = a+b -> req0_ready in cycle t, resp0_valid in cycle t+4 with resp_sum=0x40400000; resp1_valid stays 0.
2. Both valid continuously from reset, both resp_ready=1 -> grants strictly 0,1,0,1, and each response goes only to its owner.
3. resp0_ready low for 5 cycles in RESP -> resp0_valid and resp_sum held constant; req0_ready and req1_ready stay 0; no second accept.
4. DP_LAT=1 build, req1 a=0xC0A00000 b=0x40A00000 -> resp1_valid in cycle t+2 with resp_sum=0x00000000.
5. rst_n driven low during EXEC -> all outputs 0 at once; after release no response appears, and the next simultaneous request grants requester 0.
6. Checker on dp_a/dp_b through EXEC while req1 toggles operands -> no change until the next accept, and res_q matches the first operand pair.
